sram_cs_arbiter: RTL
====================

# sram_cs_arbiter

Sequences the external asynchronous SRAM's chip-select, output-enable and write-enable strobes and shares the SRAM between two requesters: port A (Nios-side bridge) and port B (board-state datapath). Each granted access runs as an atomic setup/access/hold sequence with a parameterised number of wait states. This block replaces software toggling of the chip-select PIO, so the CPU no longer drives chip-select directly.

## Interface
- `ADDR_W`, 18: SRAM word-address width.
- `DATA_W`, 16: SRAM data width.
- `WAIT_CYCLES`, 2: cycles in ACCESS state; legal range 1..15.
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `a_req` / `b_req` in 1: transfer request; held high until the matching ack.
- `a_we` / `b_we` in 1: 1 = write, 0 = read; stable while req is high.
- `a_addr` / `b_addr` in ADDR_W: word address; stable while req is high.
- `a_wdata` / `b_wdata` in DATA_W: write data; stable while req is high.
- `a_ack` / `b_ack` out 1: one-cycle completion pulse.
- `a_rdata` / `b_rdata` out DATA_W: registered read data; holds its value until that port's next read completes.
- `sram_ce_n` out 1: chip enable, active low.
- `sram_oe_n` out 1: output enable, active low.
- `sram_we_n` out 1: write enable, active low.
- `sram_addr` out ADDR_W: SRAM address.
- `sram_dq_out` out DATA_W: write data to the pad.
- `sram_dq_oe` out 1: pad output-enable; 1 = drive `sram_dq_out`.
- `sram_dq_in` in DATA_W: data from the pad.

## Operation
- FSM states: IDLE, SETUP, ACCESS, HOLD. Every SRAM output is registered.
- IDLE:
  - All strobes are high and `sram_dq_oe` is 0.
  - If any req is high, select a port, latch its we/addr/wdata, record it in `last_grant`, and go to SETUP.
- SETUP (1 cycle):
  - `ce_n`=0 and `sram_addr` is valid.
  - Read: `oe_n`=0. Write: `dq_oe`=1 with `dq_out` valid and `oe_n`=1.
  - `we_n` stays 1.
- ACCESS (`WAIT_CYCLES` cycles):
  - A down-counter is loaded with `WAIT_CYCLES`-1 on entry.
  - Write: `we_n`=0.
  - Read: `sram_dq_in` is captured into the selected port's rdata on the last ACCESS cycle.
- HOLD (1 cycle):
  - `we_n`=1 and `oe_n`=1; `ce_n`, addr and `dq_oe` are held, giving data hold after the `we_n` rise.
  - The selected port's ack is 1.
  - Next state is always IDLE, so there is at least one IDLE cycle with `ce_n`=1 between accesses.
- Arbitration is round-robin:
  - With both reqs high in IDLE, grant the port not in `last_grant`.
  - With a single req, grant it.
  - `last_grant` resets to B, so A wins the first tie.
- Requesters must drop req in the cycle after ack unless starting a new transfer. A req that is still high in IDLE is treated as a new transfer.
- Reset values: `sram_ce_n`=`oe_n`=`we_n`=1, `dq_oe`=0, `sram_addr`=0, `dq_out`=0, both acks 0, both rdata 0, state IDLE, `last_grant`=B.
- Reset asserted mid-transfer: on the next edge state=IDLE and strobes are high. No ack is issued for the aborted transfer, and rdata is not updated.
- `WAIT_CYCLES` outside 1..15 is an elaboration error.

## Timing
- Req is first seen high in IDLE at cycle n:
  - SETUP at n+1.
  - ACCESS at n+2 .. n+1+W.
  - HOLD and ack at n+2+W.
  - IDLE at n+3+W.
- Latency from req to ack is W+2 cycles. Minimum period between back-to-back accesses is W+3 cycles.
- The losing port's req stays pending, with no ack, until the next IDLE; it is then granted by round-robin.
- rdata is valid in the ack cycle and afterwards.
- A req on the other port arriving during SETUP/ACCESS/HOLD has no effect on the current transfer.

## Configuration
- `SRAM_ARB_FIXED_PRIO_EN` defined: fixed priority; port A always wins ties and `last_grant` is unused.
- `SRAM_ARB_FIXED_PRIO_EN` undefined: round-robin as specified above.

## Test plan
- Single write, W=2:
  - Stimulus: A writes 0x00123 ← 0xBEEF.
  - Response: `ce_n` low for 4 cycles; `we_n` low exactly in the 2 ACCESS cycles; `dq_oe` high from SETUP through HOLD; `a_ack` at n+4.
- Single read:
  - Stimulus: B reads 0x3FFFF while the SRAM model returns 0x5A5A.
  - Response: `oe_n` low in SETUP and ACCESS; `b_rdata`=0x5A5A in the ack cycle; `we_n` stays 1.
- Simultaneous requests:
  - Stimulus: A and B both requesting continuously after reset.
  - Response: grant order A, B, A, B; each ack 5 cycles apart for W=2.
  - With `SRAM_ARB_FIXED_PRIO_EN` and A re-requesting immediately: B is never granted while A keeps requesting.
- Reset mid-operation:
  - Stimulus: assert `reset` during ACCESS of an A write.
  - Response: next cycle `ce_n`/`we_n`=1 and `dq_oe`=0; no `a_ack`; `a_rdata` unchanged.
- WAIT_CYCLES boundaries:
  - Stimulus: read at W=1 and at W=15.
  - Response: ack at n+3 and n+17 respectively; capture happens on the last ACCESS cycle.

Source files
------------

// File: rtl/sram_cs_arbiter.sv
// Two-port arbiter and setup/access/hold strobe sequencer for an asynchronous SRAM.
// Build option: define SRAM_ARB_FIXED_PRIO_EN for fixed priority (port A wins every tie).
module sram_cs_arbiter #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_in
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("sram_cs_arbiter: WAIT_CYCLES must be within 1..15");
  end

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t              state_r;
  state_t              next_state_s;
  logic [3:0]          cnt_r;
  logic                sel_b_r;
  logic                we_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                start_s;
  logic                grant_b_s;
  logic                txn_sel_b_s;
  logic                txn_we_s;
  logic [ADDR_W-1:0]   txn_addr_s;
  logic [DATA_W-1:0]   txn_wdata_s;
  logic                capture_s;
  logic                ce_n_s;
  logic                oe_n_s;
  logic                we_n_s;
  logic                dq_oe_s;
  logic [ADDR_W-1:0]   addr_s;
  logic [DATA_W-1:0]   dq_out_s;
  logic                a_ack_s;
  logic                b_ack_s;

  assign start_s = a_req | b_req;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  // Fixed priority pick: B only wins when A is not asking.
  always_comb begin
    grant_b_s = ~a_req;
  end
`else
  logic last_grant_b_r;

  // Round-robin pick: on a tie the previous loser is granted.
  always_comb begin
    if (a_req && b_req) begin
      grant_b_s = ~last_grant_b_r;
    end else begin
      grant_b_s = b_req;
    end
  end

  // Most recent winner; B after reset so A takes the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_b_r <= 1'b1;
    end else if (state_r == IDLE && start_s) begin
      last_grant_b_r <= grant_b_s;
    end else begin
      last_grant_b_r <= last_grant_b_r;
    end
  end
`endif

  // Transfer fields: live from the winning port in IDLE, latched copy afterwards.
  always_comb begin
    if (state_r == IDLE) begin
      txn_sel_b_s = grant_b_s;
      txn_we_s    = grant_b_s ? b_we    : a_we;
      txn_addr_s  = grant_b_s ? b_addr  : a_addr;
      txn_wdata_s = grant_b_s ? b_wdata : a_wdata;
    end else begin
      txn_sel_b_s = sel_b_r;
      txn_we_s    = we_r;
      txn_addr_s  = addr_r;
      txn_wdata_s = wdata_r;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    next_state_s = start_s ? SETUP : IDLE;
      SETUP:   next_state_s = ACCESS;
      ACCESS:  next_state_s = (cnt_r == 4'd0) ? HOLD : ACCESS;
      HOLD:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register, wait counter and latched transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      sel_b_r <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
    end else begin
      state_r <= next_state_s;
      if (state_r == IDLE && start_s) begin
        sel_b_r <= txn_sel_b_s;
        we_r    <= txn_we_s;
        addr_r  <= txn_addr_s;
        wdata_r <= txn_wdata_s;
      end else begin
        sel_b_r <= sel_b_r;
        we_r    <= we_r;
        addr_r  <= addr_r;
        wdata_r <= wdata_r;
      end
      if (state_r == SETUP) begin
        cnt_r <= CNT_LOAD;
      end else if (state_r == ACCESS && cnt_r != 4'd0) begin
        cnt_r <= cnt_r - 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Pad values for the state being entered, so the registered pins line up with the state.
  always_comb begin
    ce_n_s   = 1'b1;
    oe_n_s   = 1'b1;
    we_n_s   = 1'b1;
    dq_oe_s  = 1'b0;
    addr_s   = sram_addr;
    dq_out_s = sram_dq_out;
    a_ack_s  = 1'b0;
    b_ack_s  = 1'b0;
    case (next_state_s)
      SETUP: begin
        ce_n_s  = 1'b0;
        oe_n_s  = txn_we_s;
        dq_oe_s = txn_we_s;
        addr_s  = txn_addr_s;
        if (txn_we_s) begin
          dq_out_s = txn_wdata_s;
        end else begin
          dq_out_s = sram_dq_out;
        end
      end
      ACCESS: begin
        ce_n_s  = 1'b0;
        oe_n_s  = txn_we_s;
        we_n_s  = ~txn_we_s;
        dq_oe_s = txn_we_s;
      end
      HOLD: begin
        ce_n_s  = 1'b0;
        dq_oe_s = txn_we_s;
        a_ack_s = ~txn_sel_b_s;
        b_ack_s = txn_sel_b_s;
      end
      IDLE: begin
        ce_n_s = 1'b1;
      end
      default: begin
        ce_n_s = 1'b1;
      end
    endcase
  end

  // Registered SRAM pins and acks.
  always_ff @(posedge clk) begin
    if (reset) begin
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_dq_oe  <= 1'b0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
    end else begin
      sram_ce_n   <= ce_n_s;
      sram_oe_n   <= oe_n_s;
      sram_we_n   <= we_n_s;
      sram_dq_oe  <= dq_oe_s;
      sram_addr   <= addr_s;
      sram_dq_out <= dq_out_s;
      a_ack       <= a_ack_s;
      b_ack       <= b_ack_s;
    end
  end

  assign capture_s = (state_r == ACCESS) && (cnt_r == 4'd0) && !we_r;

  // Read data is sampled from the pad on the final ACCESS cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else if (capture_s && sel_b_r) begin
      a_rdata <= a_rdata;
      b_rdata <= sram_dq_in;
    end else if (capture_s) begin
      a_rdata <= sram_dq_in;
      b_rdata <= b_rdata;
    end else begin
      a_rdata <= a_rdata;
      b_rdata <= b_rdata;
    end
  end

endmodule
